fifo_flex: RTL and testbench

Parametrised synchronous FIFO that buffers a valid/ready stream between one producer and one consumer on a single clock. It adds three things a basic pointer FIFO lacks: a synchronous flush, programmable almost-full/almost-empty thresholds, and an optional registered output stage for timing closure. It stores data in the shared `mem` primitive (combinational read) and sits on stream paths between pipeline stages that need back-pressure absorption and level feedback.

---
 rtl/fifo_flex_pkg.sv | 12 +
 rtl/fifo_flex_out_reg.sv | 26 ++
 rtl/mem.sv | 18 +
 rtl/fifo_flex.sv | 82 ++++++++
 tb/tb_fifo_flex.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/fifo_flex_pkg.sv
// fifo_flex_pkg: shared width helper and status bundle for fifo_flex
package fifo_flex_pkg;
  localparam int STATUS_CNT_W = 16;
  typedef struct packed {
    logic [STATUS_CNT_W-1:0] count;
    logic                    almost_full;
    logic                    almost_empty;
  } fifo_flex_status_t;
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_flex_out_reg.sv
// fifo_flex_out_reg: one-entry registered output stage between mem and the consumer
// ports: clk_i, arst_ni, flush_i; mem_valid_i/mem_data_i from storage head;
//        ready_i consumer accept; load_o pops storage; data_o/valid_o registered outputs
module fifo_flex_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  flush_i,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  ready_i,
  output logic                  load_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);
  // refill whenever the slot is free now or is being emptied this cycle
  assign load_o = mem_valid_i && (!valid_o || ready_i) && !flush_i;
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) valid_o <= 1'b0;
    else if (flush_i) valid_o <= 1'b0;
    else if (load_o) valid_o <= 1'b1;
    else if (ready_i) valid_o <= 1'b0;
  always_ff @(posedge clk_i)
    if (load_o) data_o <= mem_data_i;
endmodule

// File: rtl/mem.sv
// mem: shared simple dual-port storage, synchronous write, combinational read
// ports: clk_i, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o read port
module mem #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] store [2**ADDR_WIDTH];
  always_ff @(posedge clk_i)
    if (we_i) store[waddr_i] <= wdata_i;
  assign rdata_o = store[raddr_i];
endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: synchronous valid/ready FIFO with flush, almost flags and optional output register
// ports: clk_i, arst_ni (async active-low), flush_i; data_in_i/_valid_i/_ready_o producer side;
//        data_out_o/_valid_o/_ready_i consumer side; count_o level; af_thr_i/ae_thr_i thresholds;
//        almost_full_o/almost_empty_o level flags
// macro FIFO_FLEX_OUT_REG_EN adds a one-entry registered output stage (capacity depth+1)
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  data_in_valid_i,
  output logic                  data_in_ready_o,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  data_out_valid_o,
  input  logic                  data_out_ready_i,
  output logic [ADDR_WIDTH:0]   count_o,
  input  logic [ADDR_WIDTH:0]   af_thr_i,
  input  logic [ADDR_WIDTH:0]   ae_thr_i,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);
  localparam int PW = ptr_w(ADDR_WIDTH);
  logic [PW-1:0] wptr, rptr, level;
  logic [DATA_WIDTH-1:0] rdata;
  logic mem_empty, full, push, mem_pop;
  fifo_flex_status_t status;
  assign mem_empty = wptr == rptr;
  assign full = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
  assign data_in_ready_o = !full && !flush_i;
  assign push = data_in_valid_i && data_in_ready_o;
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (mem_pop) rptr <= rptr + PW'(1);
    end
  mem #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
    .clk_i  (clk_i),
    .we_i   (push),
    .waddr_i(wptr[PW-2:0]),
    .wdata_i(data_in_i),
    .raddr_i(rptr[PW-2:0]),
    .rdata_o(rdata)
  );
`ifdef FIFO_FLEX_OUT_REG_EN
  fifo_flex_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .flush_i    (flush_i),
    .mem_valid_i(!mem_empty),
    .mem_data_i (rdata),
    .ready_i    (data_out_ready_i),
    .load_o     (mem_pop),
    .data_o     (data_out_o),
    .valid_o    (data_out_valid_o)
  );
  assign level = wptr - rptr + PW'(data_out_valid_o);
`else
  assign data_out_valid_o = !mem_empty && !flush_i;
  assign data_out_o = rdata;
  assign mem_pop = data_out_valid_o && data_out_ready_i;
  assign level = wptr - rptr;
`endif
  always_comb begin
    status.count = STATUS_CNT_W'(level);
    status.almost_full = status.count >= STATUS_CNT_W'(af_thr_i);
    status.almost_empty = status.count <= STATUS_CNT_W'(ae_thr_i);
  end
  assign count_o = level;
  assign almost_full_o = status.almost_full;
  assign almost_empty_o = status.almost_empty;
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: scoreboard bench for fifo_flex (ADDR_WIDTH=2)
module tb_fifo_flex;
`ifdef FIFO_FLEX_OUT_REG_EN
  localparam int CAP = 5;
  localparam bit LAT1 = 1'b0;
`else
  localparam int CAP = 4;
  localparam bit LAT1 = 1'b1;
`endif
  logic clk = 0, arst_ni = 0, flush = 0, vin = 0, rdy = 0;
  logic [7:0] din = 0, dout;
  logic ready, vout, af, ae;
  logic [2:0] count, af_thr = 3, ae_thr = 0;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  fifo_flex #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .arst_ni(arst_ni), .flush_i(flush),
    .data_in_i(din), .data_in_valid_i(vin), .data_in_ready_o(ready),
    .data_out_o(dout), .data_out_valid_o(vout), .data_out_ready_i(rdy),
    .count_o(count), .af_thr_i(af_thr), .ae_thr_i(ae_thr),
    .almost_full_o(af), .almost_empty_o(ae)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (arst_ni) begin
    check("count", 32'(count), exp_q.size());
    check("af", 32'(af), 32'(exp_q.size() >= int'(af_thr)));
    check("ae", 32'(ae), 32'(exp_q.size() <= int'(ae_thr)));
    check("cnt_max", 32'(int'(count) <= CAP), 1);
    if (vout && rdy) begin
      if (exp_q.size() == 0) check("pop_empty", 1, 0);
      else check("data", 32'(dout), 32'(exp_q.pop_front()));
    end
    if (vin && ready) exp_q.push_back(din);
    if (flush) exp_q.delete();
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic push_word(input logic [7:0] d);
    int n = 0;
    din = d; vin = 1;
    do begin @(negedge clk); n++; end while (!ready && n < 50);
    if (!ready) check("push_to", 0, 1);
    step();
    vin = 0;
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!vout && n < 20) begin step(); n++; end
    if (!vout) check("valid_to", 0, 1);
  endtask
  task automatic drain();
    int n = 0;
    rdy = 1;
    while (vout && n < 50) begin step(); n++; end
    if (vout) check("drain_to", 0, 1);
    rdy = 0;
  endtask
  initial begin
    int sent, n;
    #12 arst_ni = 1;
    step();
    check("rst_ready", 32'(ready), 1);
    check("rst_valid", 32'(vout), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ae", 32'(ae), 1);
    check("rst_af", 32'(af), 0);
    push_word(8'h11);
    check("latency", 32'(vout), 32'(LAT1));
    for (int i = 2; i <= CAP; i++) push_word(8'(i * 8'h11));
    check("fill_count", 32'(count), CAP);
    check("fill_ready", 32'(ready), 0);
    check("fill_af", 32'(af), 1);
    drain();
    check("drain_valid", 32'(vout), 0);
    check("drain_count", 32'(count), 0);
    ae_thr = 1;
    sent = 0; n = 0;
    while ((sent < 20 || exp_q.size() != 0) && n < 600) begin
      vin = sent < 20 ? 1'($urandom_range(0, 1)) : 1'b0;
      din = 8'h60 + 8'(sent);
      rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (vin && ready) sent++;
      step();
      n++;
    end
    vin = 0; rdy = 0;
    check("wrap_done", 32'(sent == 20 && exp_q.size() == 0), 1);
    ae_thr = 0;
    push_word(8'hB1);
    push_word(8'hB2);
    wait_valid();
    din = 8'hB3; vin = 1; rdy = 1;
    @(negedge clk);
    check("sim_count_pre", 32'(count), 2);
    check("sim_hs", 32'(ready && vout), 1);
    step();
    vin = 0; rdy = 0;
    @(negedge clk);
    check("sim_count", 32'(count), 2);
    check("sim_head", 32'(dout), 32'(8'hB2));
    step();
    drain();
    push_word(8'hC1);
    push_word(8'hC2);
    push_word(8'hC3);
    flush = 1; din = 8'hEE; vin = 1; rdy = 1;
    @(negedge clk);
    check("flush_ready", 32'(ready), 0);
`ifndef FIFO_FLEX_OUT_REG_EN
    check("flush_valid", 32'(vout), 0);
`endif
    step();
    flush = 0; vin = 0; rdy = 0;
    check("flush_count", 32'(count), 0);
    push_word(8'hA5);
    wait_valid();
    check("flush_head", 32'(dout), 32'(8'hA5));
    af_thr = 0; ae_thr = 4;
    @(negedge clk);
    check("af_zero", 32'(af), 1);
    check("ae_depth", 32'(ae), 1);
    step();
    af_thr = 3; ae_thr = 0;
    push_word(8'hD1);
    #2 arst_ni = 0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_valid", 32'(vout), 0);
    exp_q.delete();
    step();
    arst_ni = 1;
    push_word(8'h5A);
    wait_valid();
    check("post_arst_head", 32'(dout), 32'(8'h5A));
    drain();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
